dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of CPU and bus ports.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port cpu_mem_read_en  input  1  CPU load request, presented in the CPU EX cycle.
REQ-006 Port cpu_mem_write_en  input  4  CPU byte write enables; bit 3 is byte address 0 (big-endian lanes).
REQ-007 Port cpu_mem_addr  input  ADDR_W  CPU byte address.
REQ-008 Port cpu_mem_write_data  input  32  CPU store data, already lane-replicated.
REQ-009 Port cpu_mem_read_data  output  32  load data returned to the CPU M stage.
REQ-010 Port cpu_stall  output  1  hold request; the CPU top drives its enable as en & ~cpu_stall.
REQ-011 Port bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-012 Port bus_req_we  output  4  byte enables; 0 means read.
REQ-013 Port bus_req_addr  output  ADDR_W  word-aligned address, bits [1:0] = 0.
REQ-014 Port bus_req_wdata  output  32  write data.
REQ-015 Port bus_rsp_valid, bus_rsp_rdata, bus_rsp_err  input  1, 32, 1  response; exactly one response per accepted request.
REQ-016 Port err_sticky  output  1  latched bus error flag.

Function
REQ-017 A request is cpu_mem_read_en | (|cpu_mem_write_en); simultaneous read and write is illegal; write wins.
REQ-018 FSM states: IDLE, REQ, RESP, DONE.
REQ-019 In IDLE with a request, the block captures addr/we/wdata, asserts cpu_stall combinationally in the same cycle, and moves to REQ.
REQ-020 In REQ, bus_req_valid=1 with fields held stable until bus_req_ready=1; the block moves to RESP on that edge.
REQ-021 In RESP, the block waits for bus_rsp_valid, registers bus_rsp_rdata into rdata_q, and moves to DONE.
REQ-022 cpu_stall=1 in REQ and RESP and 0 in DONE; DONE moves to IDLE unconditionally.
REQ-023 cpu_mem_read_data=rdata_q, held until the next read completes; it is valid the cycle after DONE, matching the CPU M-stage timing.
REQ-024 Minimum latency with ready=1 and the response on the next cycle: request cycle 0, stall asserted in cycles 0-2, released in cycle 3.
REQ-025 A response with bus_rsp_err=1 sets err_sticky and loads rdata_q=32'h0; the transaction still completes.
REQ-026 A bus_rsp_valid outside RESP is ignored.

Reset
REQ-027 rst forces IDLE immediately, with bus_req_valid=0, cpu_stall=0, rdata_q=0, err_sticky=0, and write buffer empty.
REQ-028 A reset during REQ/RESP abandons the transaction, and a later stray response is ignored per REQ-026.

Configuration
REQ-029 Macro DMEM_BRIDGE_WBUF_EN: when defined, a one-entry posted write buffer is compiled in.
REQ-030 With the macro, a write in IDLE with an empty buffer is captured without asserting cpu_stall and drained via REQ/RESP in the background.
REQ-031 With the macro, any request arriving while the buffer drains stalls until the drain completes, preserving program order.
REQ-032 Without the macro, writes stall exactly like reads (REQ-019..022).

Structure
REQ-033 The state encoding, the DATA_W/ADDR_W defaults and the error read value live in shared package mips_mem_pkg.
REQ-034 There are no sub-modules; the FSM, capture registers and optional buffer are a single module.

Verification
REQ-035 Load from 0x100, ready=1, rsp next cycle with 0xCAFEF00D -> stall high for exactly 3 cycles; read_data=0xCAFEF00D the cycle after DONE.
REQ-036 Store we=4'b0010 to 0x203, data 0x11111111, ready delayed 4 cycles -> bus_req_addr=0x200 and we=4'b0010 held stable; stall held until the response.
REQ-037 Load with bus_rsp_err=1 -> err_sticky=1 persists; read_data=0; the next load succeeds normally.
REQ-038 rst pulsed while in RESP -> IDLE immediately; stall=0; a later bus_rsp_valid causes no state change.
REQ-039 With DMEM_BRIDGE_WBUF_EN: store then load on back-to-back cycles -> store has no stall; load stalls until the store response; bus order is write then read.
REQ-040 Without DMEM_BRIDGE_WBUF_EN: the same sequence -> the store stalls 3 cycles, then the load stalls 3 cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, default widths,
// the value returned on a failed load, and the captured write payload.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned BE_W           = 4;

    // Load data returned when the bus flags an error
    localparam logic [DATA_W_DEFAULT-1:0] ERR_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    // Captured byte enables and store data for the outstanding bus request
    typedef struct packed {
        logic [BE_W-1:0]           we;
        logic [DATA_W_DEFAULT-1:0] wdata;
    } dmem_wr_t;

endpackage

// File: rtl/dmem_bridge.sv
// CPU data-memory port to valid/ready bus bridge. One transaction at a time:
// IDLE captures the access, REQ presents it on the bus, RESP waits for the
// response, DONE releases the CPU for one cycle before returning to IDLE.
// Optional feature macro DMEM_BRIDGE_WBUF_EN: one-entry posted write buffer;
// a store accepted in IDLE does not stall and is drained in the background.
module dmem_bridge
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mem_read_en,
    input  logic [BE_W-1:0]   cpu_mem_write_en,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_write_data,
    output logic [DATA_W-1:0] cpu_mem_read_data,
    output logic              cpu_stall,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [BE_W-1:0]   bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_rdata,
    input  logic              bus_rsp_err,
    output logic              err_sticky
);

    // Only a 32-bit data path is implemented
    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_bridge: DATA_W must be 32");
    end

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    dmem_wr_t          wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic cpu_req;
    logic cpu_wr;
    logic capture;
    logic rsp_take;
    logic unused_addr_lsb;

    // Write wins when read and write are presented together
    assign cpu_wr   = |cpu_mem_write_en;
    assign cpu_req  = cpu_mem_read_en | cpu_wr;
    assign capture  = (state_q == ST_IDLE) & cpu_req;
    assign rsp_take = (state_q == ST_RESP) & bus_rsp_valid;

    // Byte offset is dropped; the bus is word addressed
    assign unused_addr_lsb = ^cpu_mem_addr[1:0];

`ifdef DMEM_BRIDGE_WBUF_EN
    logic posted_q;

    // Marks the in-flight transaction as a posted store the CPU has moved past
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            posted_q <= 1'b0;
        end else if (capture) begin
            posted_q <= cpu_wr;
        end else if (state_q == ST_DONE) begin
            posted_q <= 1'b0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cpu_req)       state_d = ST_REQ;
            ST_REQ:  if (bus_req_ready) state_d = ST_RESP;
            ST_RESP: if (bus_rsp_valid) state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Stall and request-valid decode; reset drops the stall immediately
    always_comb begin
        cpu_stall     = 1'b0;
        bus_req_valid = 1'b0;
        unique case (state_q)
`ifdef DMEM_BRIDGE_WBUF_EN
            // A store posts; anything arriving during a drain waits for it
            ST_IDLE: cpu_stall = cpu_req & ~cpu_wr;
            ST_REQ: begin
                bus_req_valid = 1'b1;
                cpu_stall     = posted_q ? cpu_req : 1'b1;
            end
            ST_RESP: cpu_stall = posted_q ? cpu_req : 1'b1;
            ST_DONE: cpu_stall = posted_q & cpu_req;
`else
            ST_IDLE: cpu_stall = cpu_req;
            ST_REQ: begin
                bus_req_valid = 1'b1;
                cpu_stall     = 1'b1;
            end
            ST_RESP: cpu_stall = 1'b1;
            ST_DONE: cpu_stall = 1'b0;
`endif
            default: cpu_stall = 1'b0;
        endcase
        if (rst) begin
            cpu_stall = 1'b0;
        end
    end

    // Request capture; fields stay stable until the next IDLE capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            wr_q   <= '0;
        end else if (capture) begin
            addr_q <= {cpu_mem_addr[ADDR_W-1:2], 2'b00};
            wr_q   <= '{we: cpu_mem_write_en, wdata: cpu_mem_write_data};
        end
    end

    // Load data and sticky error; store responses leave the load data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (rsp_take) begin
            if (wr_q.we == '0) begin
                rdata_q <= bus_rsp_err ? DATA_W'(ERR_RDATA) : bus_rsp_rdata;
            end
            if (bus_rsp_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_req_addr      = addr_q;
    assign bus_req_we        = wr_q.we;
    assign bus_req_wdata     = wr_q.wdata;
    assign cpu_mem_read_data = rdata_q;
    assign err_sticky        = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a bus responder with programmable ready delay
// and a CPU-side task that presents one access and counts its stall cycles.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_mem_read_en = 1'b0;
    logic [3:0]  cpu_mem_write_en = 4'b0;
    logic [31:0] cpu_mem_addr = 32'h0;
    logic [31:0] cpu_mem_write_data = 32'h0;
    logic [31:0] cpu_mem_read_data;
    logic        cpu_stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [3:0]  bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;
    logic        err_sticky;

    dmem_bridge dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_mem_read_en    (cpu_mem_read_en),
        .cpu_mem_write_en   (cpu_mem_write_en),
        .cpu_mem_addr       (cpu_mem_addr),
        .cpu_mem_write_data (cpu_mem_write_data),
        .cpu_mem_read_data  (cpu_mem_read_data),
        .cpu_stall          (cpu_stall),
        .bus_req_valid      (bus_req_valid),
        .bus_req_ready      (bus_req_ready),
        .bus_req_we         (bus_req_we),
        .bus_req_addr       (bus_req_addr),
        .bus_req_wdata      (bus_req_wdata),
        .bus_rsp_valid      (bus_rsp_valid),
        .bus_rsp_rdata      (bus_rsp_rdata),
        .bus_rsp_err        (bus_rsp_err),
        .err_sticky         (err_sticky)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Responder configuration (written by the main sequence)
    int          ready_delay = 0;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_err = 1'b0;
    logic        rsp_mute = 1'b0;
    logic        rsp_inject = 1'b0;

    // Responder state and accepted-request log
    int          vcnt = 0;
    logic        rsp_pend = 1'b0;
    logic        waiting = 1'b0;
    logic        unstable = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_we;
    logic [31:0] log_addr [16];
    logic [3:0]  log_we   [16];
    logic [31:0] log_wd   [16];
    int          nlog = 0;

    // Bus slave: ready after ready_delay valid cycles, response one cycle after accept
    initial begin
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'h0;
        bus_rsp_err   = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus_rsp_valid = (rsp_pend && !rsp_mute) || rsp_inject;
            bus_rsp_rdata = rsp_inject ? 32'hDEAD_BEEF : rsp_data;
            bus_rsp_err   = rsp_pend && rsp_err && !rsp_inject;
            rsp_pend      = 1'b0;
            bus_req_ready = (vcnt >= ready_delay);
            @(negedge clk);
            if (rst) begin
                vcnt    = 0;
                waiting = 1'b0;
            end else if (bus_req_valid) begin
                if (waiting && (bus_req_addr !== held_addr || bus_req_we !== held_we ||
                                bus_req_wdata !== held_wdata))
                    unstable = 1'b1;
                if (bus_req_ready) begin
                    if (nlog < 16) begin
                        log_addr[nlog] = bus_req_addr;
                        log_we[nlog]   = bus_req_we;
                        log_wd[nlog]   = bus_req_wdata;
                    end
                    nlog++;
                    rsp_pend = 1'b1;
                    vcnt     = 0;
                    waiting  = 1'b0;
                end else begin
                    vcnt++;
                    waiting    = 1'b1;
                    held_addr  = bus_req_addr;
                    held_we    = bus_req_we;
                    held_wdata = bus_req_wdata;
                end
            end
        end
    end

    // Present one access starting at posedge+1; hold it while stalled and
    // return at posedge+1 after the cycle in which the CPU advanced
    task automatic cpu_op(input logic rd, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wd, output int stalls);
        logic done;
        done   = 1'b0;
        stalls = 0;
        cpu_mem_read_en    = rd;
        cpu_mem_write_en   = we;
        cpu_mem_addr       = addr;
        cpu_mem_write_data = wd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        chk("op_complete", 32'(done), 32'd1);
        @(posedge clk); #1;
        cpu_mem_read_en    = 1'b0;
        cpu_mem_write_en   = 4'b0;
        cpu_mem_addr       = 32'h0;
        cpu_mem_write_data = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    int s1, s2, base;

    initial begin
        // Reset state
        #2;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_rdata", cpu_mem_read_data, 32'h0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Minimum-latency load
        ready_delay = 0; rsp_data = 32'hCAFE_F00D; rsp_err = 1'b0;
        base = nlog;
        cpu_op(1'b1, 4'b0000, 32'h0000_0100, 32'h0, s1);
        chk("ld_stalls", 32'(s1), 32'd3);
        chk("ld_rdata", cpu_mem_read_data, 32'hCAFE_F00D);
        chk("ld_addr", log_addr[base], 32'h0000_0100);
        chk("ld_we", 32'(log_we[base]), 32'd0);
        chk("ld_idle_valid", 32'(bus_req_valid), 32'd0);

        // Unaligned store with a slow ready
        ready_delay = 4; rsp_data = 32'h5555_5555; unstable = 1'b0;
        base = nlog;
        cpu_op(1'b0, 4'b0010, 32'h0000_0203, 32'h1111_1111, s1);
        chk("st_stalls", 32'(s1), 32'd7);
        chk("st_addr", log_addr[base], 32'h0000_0200);
        chk("st_we", 32'(log_we[base]), 32'b0010);
        chk("st_wdata", log_wd[base], 32'h1111_1111);
        chk("st_stable", 32'(unstable), 32'd0);
        chk("st_rdata_held", cpu_mem_read_data, 32'hCAFE_F00D);

        // Load with bus error, then a clean load
        ready_delay = 0; rsp_data = 32'h9999_9999; rsp_err = 1'b1;
        cpu_op(1'b1, 4'b0000, 32'h0000_0300, 32'h0, s1);
        chk("err_stalls", 32'(s1), 32'd3);
        chk("err_rdata", cpu_mem_read_data, 32'h0);
        chk("err_flag", 32'(err_sticky), 32'd1);
        rsp_err = 1'b0; rsp_data = 32'h1234_5678;
        cpu_op(1'b1, 4'b0000, 32'h0000_0304, 32'h0, s1);
        chk("err_next_rdata", cpu_mem_read_data, 32'h1234_5678);
        chk("err_persist", 32'(err_sticky), 32'd1);

        // Reset while waiting in RESP, then a stray response
        rsp_mute = 1'b1; ready_delay = 0;
        cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h0000_0400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_stall", 32'(cpu_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mid_valid", 32'(bus_req_valid), 32'd0);
        cpu_mem_read_en = 1'b0; cpu_mem_addr = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_mute = 1'b0;
        @(negedge clk);
        rsp_inject = 1'b1;
        @(negedge clk);
        rsp_inject = 1'b0;
        chk("stray_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        chk("stray_valid", 32'(bus_req_valid), 32'd0);
        chk("stray_rdata", cpu_mem_read_data, 32'h0);
        chk("stray_err", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;

        // Store immediately followed by a load
        ready_delay = 0; rsp_data = 32'hA5A5_5A5A; rsp_err = 1'b0;
        base = nlog;
        cpu_op(1'b0, 4'b1111, 32'h0000_0500, 32'h7777_7777, s1);
        cpu_op(1'b1, 4'b0000, 32'h0000_0504, 32'h0, s2);
`ifdef DMEM_BRIDGE_WBUF_EN
        chk("seq_st_stalls", 32'(s1), 32'd0);
        chk("seq_ld_stalls", 32'(s2), 32'd6);
`else
        chk("seq_st_stalls", 32'(s1), 32'd3);
        chk("seq_ld_stalls", 32'(s2), 32'd3);
`endif
        chk("seq_nreq", 32'(nlog - base), 32'd2);
        chk("seq_first_we", 32'(log_we[base]), 32'hF);
        chk("seq_first_addr", log_addr[base], 32'h0000_0500);
        chk("seq_second_we", 32'(log_we[base+1]), 32'd0);
        chk("seq_second_addr", log_addr[base+1], 32'h0000_0504);
        chk("seq_rdata", cpu_mem_read_data, 32'hA5A5_5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
